pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Fetch/execute sequencer for the Hack-style 16-bit program counter.
- Requests instructions from instruction ROM over a req/ack handshake and hands each one to the datapath.
- Evaluates the jump condition from the instruction and the ALU flags, then drives the PC's in/inc/load/reset controls for exactly one cycle per instruction.
- Detects jump-to-self (program end) and ROM timeouts.

Parameters:
WIDTH, 16, data/address width of instruction, PC and A register.
ACK_TIMEOUT, 15, maximum FETCH cycles waiting for rom_ack before fault; 0 disables the watchdog.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
run  in  1  level; 1 = execute, 0 = pause/stop.
rom_req  out  1  instruction fetch request.
rom_ack  in  1  ROM has valid data on instr this cycle.
instr  in  WIDTH  ROM data, sampled only when rom_req & rom_ack.
pc_q  in  WIDTH  current PC output.
a_reg  in  WIDTH  A register value, the jump target.
zr  in  1  ALU result == 0 for the current C-instruction.
ng  in  1  ALU result < 0.
exec_done  in  1  datapath has finished the current instruction; flags are valid.
exec_start  out  1  one-cycle pulse, instr_q is valid.
instr_q  out  WIDTH  latched instruction.
pc_in  out  WIDTH  load value for the PC.
pc_inc  out  1  PC increment.
pc_load  out  1  PC load.
pc_reset  out  1  PC synchronous clear.
halted  out  1  1 while in HALT.
timeout  out  1  sticky ROM-timeout fault.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all outputs 0, including instr_q, pc_in and timeout; watchdog=0. Takes effect mid-operation immediately, with no PC update issued.
- States: IDLE, FETCH, EXEC, UPDATE, PAUSE, HALT. Controls are Moore decodes of the state plus a registered jump bit.
- IDLE: pc_reset=1 while run=1, then go to FETCH. The PC starts from 0 on every start.
- FETCH: rom_req=1. On rom_ack: instr_q<=instr, watchdog cleared, go to EXEC. Otherwise the watchdog increments.
- Watchdog fault: if the watchdog reaches ACK_TIMEOUT (and ACK_TIMEOUT!=0), set timeout=1 and go to HALT. If rom_ack and the timeout arrive in the same cycle, ack wins.
- EXEC: exec_start=1 in the first EXEC cycle only. exec_done is accepted in any EXEC cycle, including the first.
- On exec_done: jump<=instr_q[15] & ((instr_q[2]&ng) | (instr_q[1]&zr) | (instr_q[0]&~zr&~ng)); pc_in<=a_reg; self<=(a_reg==pc_q). Then go to UPDATE.
- A-instructions (bit15=0) never jump.
- UPDATE: exactly one cycle. pc_load=jump, pc_inc=~jump; the two are never both 1. pc_in is held until the next UPDATE.
- UPDATE next state: if jump & self, go to HALT. Else if run=0, go to PAUSE. Else go to FETCH.
- PAUSE: no PC controls. run=1 goes to FETCH, continuing from the current PC.
- HALT: halted=1, no PC controls. run=0 goes to IDLE. timeout is cleared only by reset_n.
- Throughput: minimum 3 cycles per instruction (ack in the first FETCH cycle, exec_done in the first EXEC cycle).
- run falling during FETCH or EXEC: the current instruction completes; the pause is taken after UPDATE.
- PC wrap-around (0xFFFF to 0x0000) is the PC's concern; the sequencer does not check it.

Optional Feature:
PC_SEQ_SINGLE_STEP_EN
- Defined: adds input step (1 bit). In PAUSE, a step=1 cycle with run=0 executes exactly one instruction (FETCH, EXEC, UPDATE) and returns to PAUSE. step is ignored outside PAUSE. If step and run are both 1, run wins.
- Undefined: no step port; PAUSE is left only via run=1.

Decomposition:
- Package pc_seq_pkg holds: state enum, WIDTH default, jump-field bit positions (J_LT=2, J_EQ=1, J_GT=0, CINSTR_BIT=15).
- One combinational sub-module, hack_jump_cond: inputs instr[2:0], instr[15], zr, ng; output jump.

Test Plan:
- Reset then run=1; ROM acks in 1 cycle; program of A-instructions with exec_done immediate -> pc_reset one cycle, then pc_inc once every 3 cycles; PC sequence 0,1,2,3.
- C-instruction with instr[2:0]=3'b111 (JMP), a_reg=16'd100, pc_q=5 -> pc_load=1, pc_in=100, pc_inc=0 in UPDATE. Same instruction with [2:0]=3'b010, zr=0 -> pc_inc=1, no load.
- Jump-to-self: a_reg=16'd7, pc_q=7, JMP -> load issued once, then halted=1 with no further controls. Drop run -> IDLE; raise run -> pc_reset.
- rom_ack held 0 with ACK_TIMEOUT=15 -> timeout=1 and halted=1 after 15 FETCH cycles. rom_ack arriving on cycle 15 -> no timeout.
- run dropped during EXEC -> UPDATE still issued, then PAUSE. With the macro defined, a step pulse -> exactly one more pc_inc.
- reset_n pulsed low during EXEC -> all outputs 0 asynchronously, no pc_load/pc_inc issued, timeout cleared.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the Hack-style PC fetch/execute sequencer.
// Optional single-step support is enabled by defining PC_SEQ_SINGLE_STEP_EN.
package pc_seq_pkg;

  localparam int PC_WIDTH   = 16;

  // Jump field and instruction-class bit positions in a Hack C-instruction
  localparam int J_LT       = 2;
  localparam int J_EQ       = 1;
  localparam int J_GT       = 0;
  localparam int CINSTR_BIT = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_UPDATE,
    S_PAUSE,
    S_HALT
  } state_t;

endpackage

// File: rtl/hack_jump_cond.sv
// Combinational Hack jump-condition evaluation from the jjj field and ALU flags.
// A-instructions (class bit clear) never jump.
module hack_jump_cond
  import pc_seq_pkg::*;
(
  input  logic [2:0] i_jbits,
  input  logic       i_cinstr,
  input  logic       i_zr,
  input  logic       i_ng,
  output logic       o_jump
);

  logic w_lt;
  logic w_eq;
  logic w_gt;

  assign w_lt   = i_jbits[J_LT] & i_ng;
  assign w_eq   = i_jbits[J_EQ] & i_zr;
  assign w_gt   = i_jbits[J_GT] & ~i_zr & ~i_ng;
  assign o_jump = i_cinstr & (w_lt | w_eq | w_gt);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer driving the Hack PC: ROM fetch handshake, jump decision,
// program-end (jump-to-self) detection and ROM-ack watchdog. Define PC_SEQ_SINGLE_STEP_EN for a step input.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int WIDTH       = PC_WIDTH,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
`ifdef PC_SEQ_SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic             rom_req,
  input  logic             rom_ack,
  input  logic [WIDTH-1:0] instr,
  input  logic [WIDTH-1:0] pc_q,
  input  logic [WIDTH-1:0] a_reg,
  input  logic             zr,
  input  logic             ng,
  input  logic             exec_done,
  output logic             exec_start,
  output logic [WIDTH-1:0] instr_q,
  output logic [WIDTH-1:0] pc_in,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             pc_reset,
  output logic             halted,
  output logic             timeout
);

  localparam int WD_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  state_t          r_state;
  logic [WIDTH-1:0] r_instr_q;
  logic [WIDTH-1:0] r_pc_in;
  logic            r_jump;
  logic            r_self;
  logic [WD_W-1:0] r_wdog;
  logic            r_timeout;
  logic            r_rom_req;
  logic            r_exec_start;
  logic            r_pc_inc;
  logic            r_pc_load;
  logic            r_halted;
  logic            w_jump;
  logic            w_resume;
  logic            w_wdog_expired;

  hack_jump_cond u_jump_cond (
    .i_jbits  (r_instr_q[2:0]),
    .i_cinstr (r_instr_q[CINSTR_BIT]),
    .i_zr     (zr),
    .i_ng     (ng),
    .o_jump   (w_jump)
  );

`ifdef PC_SEQ_SINGLE_STEP_EN
  // run has priority; a step with run low runs one instruction and UPDATE falls back to PAUSE
  assign w_resume = run | step;
`else
  assign w_resume = run;
`endif

  assign w_wdog_expired = (ACK_TIMEOUT != 0) && ((int'(r_wdog) + 1) == ACK_TIMEOUT);

  // Control pulses are registered on entry to their state so they line up with it exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_instr_q    <= '0;
      r_pc_in      <= '0;
      r_jump       <= 1'b0;
      r_self       <= 1'b0;
      r_wdog       <= '0;
      r_timeout    <= 1'b0;
      r_rom_req    <= 1'b0;
      r_exec_start <= 1'b0;
      r_pc_inc     <= 1'b0;
      r_pc_load    <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_rom_req    <= 1'b0;
      r_exec_start <= 1'b0;
      r_pc_inc     <= 1'b0;
      r_pc_load    <= 1'b0;
      r_halted     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_wdog <= '0;
          if (run) begin
            r_state   <= S_FETCH;
            r_rom_req <= 1'b1;
          end
        end
        S_FETCH: begin
          if (rom_ack) begin
            r_instr_q    <= instr;
            r_wdog       <= '0;
            r_state      <= S_EXEC;
            r_exec_start <= 1'b1;
          end else if (w_wdog_expired) begin
            r_timeout <= 1'b1;
            r_wdog    <= '0;
            r_state   <= S_HALT;
            r_halted  <= 1'b1;
          end else begin
            r_wdog    <= r_wdog + WD_W'(1);
            r_rom_req <= 1'b1;
          end
        end
        S_EXEC: begin
          if (exec_done) begin
            r_jump    <= w_jump;
            r_pc_in   <= a_reg;
            r_self    <= (a_reg == pc_q);
            r_pc_load <= w_jump;
            r_pc_inc  <= ~w_jump;
            r_state   <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          if (r_jump && r_self) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else if (!run) begin
            r_state <= S_PAUSE;
          end else begin
            r_state   <= S_FETCH;
            r_rom_req <= 1'b1;
          end
        end
        S_PAUSE: begin
          if (w_resume) begin
            r_state   <= S_FETCH;
            r_rom_req <= 1'b1;
          end
        end
        S_HALT: begin
          if (!run) begin
            r_state <= S_IDLE;
          end else begin
            r_halted <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rom_req    = r_rom_req;
  assign exec_start = r_exec_start;
  assign instr_q    = r_instr_q;
  assign pc_in      = r_pc_in;
  assign pc_inc     = r_pc_inc;
  assign pc_load    = r_pc_load;
  assign halted     = r_halted;
  assign timeout    = r_timeout;
  // Clear is requested during the IDLE cycle itself so the first fetch already sees PC=0
  assign pc_reset   = reset_n & run & (r_state == S_IDLE);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; step tests are built when PC_SEQ_SINGLE_STEP_EN is defined.
`timescale 1ns/1ps
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
`ifdef PC_SEQ_SINGLE_STEP_EN
  logic        step = 1'b0;
`endif
  logic        rom_req;
  logic        rom_ack;
  logic [15:0] instr = '0;
  logic [15:0] pc_q;
  logic [15:0] a_reg = '0;
  logic        zr = 1'b0;
  logic        ng = 1'b0;
  logic        exec_done;
  logic        exec_start;
  logic [15:0] instr_q;
  logic [15:0] pc_in;
  logic        pc_inc;
  logic        pc_load;
  logic        pc_reset;
  logic        halted;
  logic        timeout;

  logic        ack_en = 1'b1;
  logic        done_auto = 1'b1;
  logic        done_force = 1'b0;
  logic        pc_ovr_en = 1'b0;
  logic [15:0] pc_ovr = '0;
  logic [15:0] pc_model = '0;
  int          n_vec = 0;
  int          n_err = 0;

  // {rom_req, exec_start, pc_inc, pc_load, pc_reset, halted, timeout}
  wire [6:0] ctl = {rom_req, exec_start, pc_inc, pc_load, pc_reset, halted, timeout};

  always #5 clk = ~clk;

  assign rom_ack   = rom_req & ack_en;
  assign exec_done = (done_auto & exec_start) | done_force;
  assign pc_q      = pc_ovr_en ? pc_ovr : pc_model;

  // Behavioural Hack PC driven by the sequencer's controls
  always @(posedge clk) begin
    if (pc_reset)     pc_model <= '0;
    else if (pc_load) pc_model <= pc_in;
    else if (pc_inc)  pc_model <= pc_model + 16'd1;
  end

  pc_sequencer #(.WIDTH(16), .ACK_TIMEOUT(15)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (run),
`ifdef PC_SEQ_SINGLE_STEP_EN
    .step       (step),
`endif
    .rom_req    (rom_req),
    .rom_ack    (rom_ack),
    .instr      (instr),
    .pc_q       (pc_q),
    .a_reg      (a_reg),
    .zr         (zr),
    .ng         (ng),
    .exec_done  (exec_done),
    .exec_start (exec_start),
    .instr_q    (instr_q),
    .pc_in      (pc_in),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .pc_reset   (pc_reset),
    .halted     (halted),
    .timeout    (timeout)
  );

  // Reset, release, raise run: expects the clear pulse in IDLE then the first FETCH cycle.
  task automatic start_seq();
    @(negedge clk);
    reset_n = 1'b0; run = 1'b0; pc_ovr_en = 1'b0;
    #3 reset_n = 1'b1;
    @(negedge clk);
    run = 1'b1;
    #1;
    n_vec++;
    if (ctl !== 7'b0000100) begin
      n_err++; $display("FAIL start_pc_reset: got ctl=%b want %b", ctl, 7'b0000100);
    end
    @(negedge clk);
    n_vec++;
    if (ctl !== 7'b1000000) begin
      n_err++; $display("FAIL start_fetch: got ctl=%b want %b", ctl, 7'b1000000);
    end
  endtask

  // Called at a FETCH-cycle negedge with ack and immediate exec_done; ends at the UPDATE negedge.
  task automatic run_instr(input logic [15:0] ins, input logic [15:0] a, input logic z,
                           input logic n, input logic exp_load);
    logic [5:0] exp_upd;
    exp_upd = exp_load ? 6'b000100 : 6'b001000;
    instr = ins; a_reg = a; zr = z; ng = n;
    @(negedge clk);
    n_vec++;
    if (ctl[6:1] !== 6'b010000 || instr_q !== ins) begin
      n_err++; $display("FAIL exec_%h: got ctl=%b instr_q=%h want ctl=010000x instr_q=%h",
                        ins, ctl, instr_q, ins);
    end
    @(negedge clk);
    n_vec++;
    if (ctl[6:1] !== exp_upd || pc_in !== a) begin
      n_err++; $display("FAIL update_%h: got ctl=%b pc_in=%0d want ctl=%bx pc_in=%0d",
                        ins, ctl, pc_in, exp_upd, a);
    end
    $display("instr %h a=%0d zr=%0b ng=%0b pc_q=%0d -> load=%0b inc=%0b pc_in=%0d",
             ins, a, z, n, pc_q, pc_load, pc_inc, pc_in);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; run = 1'b1;
    #12;
    n_vec++;
    if (ctl !== 7'b0) begin
      n_err++; $display("FAIL reset_ctl: got %b want 0000000", ctl);
    end
    n_vec++;
    if (instr_q !== 16'h0 || pc_in !== 16'h0) begin
      n_err++; $display("FAIL reset_data: got instr_q=%h pc_in=%h want 0000 0000", instr_q, pc_in);
    end
    run = 1'b0;
    $display("reset applied");
  endtask

  task automatic test_a_instr();
    start_seq();
    for (int i = 0; i < 4; i++) begin
      if (i != 0) begin
        @(negedge clk);
        n_vec++;
        if (ctl !== 7'b1000000 || pc_q !== 16'(i)) begin
          n_err++; $display("FAIL a_fetch_%0d: got ctl=%b pc=%0d want 1000000 pc=%0d", i, ctl, pc_q, i);
        end
      end
      run_instr(16'h0007 | 16'(i << 4), 16'h0100 + 16'(i), i[0], i[1], 1'b0);
    end
  endtask

  task automatic test_jump_cond();
    start_seq();
    pc_ovr_en = 1'b1; pc_ovr = 16'd5;
    run_instr(16'hE007, 16'd100, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    run_instr(16'hE002, 16'd100, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    run_instr(16'hE004, 16'd200, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    run_instr(16'hE001, 16'd300, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    run_instr(16'hE001, 16'd300, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    run_instr(16'hE002, 16'd40, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    run_instr(16'hE006, 16'd41, 1'b0, 1'b0, 1'b0);
    pc_ovr_en = 1'b0;
  endtask

  task automatic test_jump_self();
    start_seq();
    pc_ovr_en = 1'b1; pc_ovr = 16'd7;
    run_instr(16'hE007, 16'd7, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (ctl !== 7'b0000010) begin
        n_err++; $display("FAIL halt_%0d: got ctl=%b want 0000010", i, ctl);
      end
    end
    run = 1'b0;
    @(negedge clk);
    n_vec++;
    if (ctl !== 7'b0) begin
      n_err++; $display("FAIL halt_to_idle: got ctl=%b want 0000000", ctl);
    end
    run = 1'b1;
    #1;
    n_vec++;
    if (ctl !== 7'b0000100) begin
      n_err++; $display("FAIL restart_pc_reset: got ctl=%b want 0000100", ctl);
    end
    pc_ovr_en = 1'b0;
    $display("jump-to-self halted and restarted");
  endtask

  task automatic test_pause();
    logic [15:0] exp_pc;
    start_seq();
    done_auto = 1'b0; instr = 16'h0000; a_reg = 16'd9;
    @(negedge clk);
    n_vec++;
    if (ctl !== 7'b0100000) begin
      n_err++; $display("FAIL pause_exec1: got ctl=%b want 0100000", ctl);
    end
    run = 1'b0;
    @(negedge clk);
    n_vec++;
    if (ctl !== 7'b0) begin
      n_err++; $display("FAIL pause_exec2: got ctl=%b want 0000000", ctl);
    end
    done_force = 1'b1;
    @(negedge clk);
    done_force = 1'b0;
    n_vec++;
    if (ctl !== 7'b0010000) begin
      n_err++; $display("FAIL pause_update: got ctl=%b want 0010000", ctl);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_vec++;
      if (ctl !== 7'b0) begin
        n_err++; $display("FAIL pause_hold_%0d: got ctl=%b want 0000000", i, ctl);
      end
    end
    exp_pc = 16'd1;
    done_auto = 1'b1;
`ifdef PC_SEQ_SINGLE_STEP_EN
    begin
      int incs;
      incs = 0;
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      n_vec++;
      if (ctl !== 7'b1000000) begin
        n_err++; $display("FAIL step_fetch: got ctl=%b want 1000000", ctl);
      end
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        incs += int'(pc_inc);
      end
      n_vec++;
      if (incs != 1 || ctl !== 7'b0) begin
        n_err++; $display("FAIL step_one_inc: got incs=%0d ctl=%b want 1 0000000", incs, ctl);
      end
      exp_pc = 16'd2;
    end
`endif
    run = 1'b1;
    @(negedge clk);
    n_vec++;
    if (ctl !== 7'b1000000 || pc_q !== exp_pc) begin
      n_err++; $display("FAIL pause_resume: got ctl=%b pc=%0d want 1000000 pc=%0d", ctl, pc_q, exp_pc);
    end
    $display("pause/resume at pc=%0d", pc_q);
  endtask

  task automatic test_ack_at_limit();
    ack_en = 1'b0;
    start_seq();
    repeat (14) @(negedge clk);
    ack_en = 1'b1; instr = 16'h0003;
    @(negedge clk);
    n_vec++;
    if (ctl !== 7'b0100000) begin
      n_err++; $display("FAIL ack_at_limit: got ctl=%b want 0100000", ctl);
    end
    $display("ack on fetch cycle 15 accepted");
  endtask

  task automatic test_timeout();
    ack_en = 1'b0;
    start_seq();
    repeat (14) @(negedge clk);
    n_vec++;
    if (ctl !== 7'b1000000) begin
      n_err++; $display("FAIL timeout_cycle15: got ctl=%b want 1000000", ctl);
    end
    @(negedge clk);
    n_vec++;
    if (ctl !== 7'b0000011) begin
      n_err++; $display("FAIL timeout_fault: got ctl=%b want 0000011", ctl);
    end
    $display("rom timeout after 15 fetch cycles");
  endtask

  // Continues from the timeout HALT so the sticky fault is visible until reset_n clears it.
  task automatic test_reset_in_exec();
    run = 1'b0; ack_en = 1'b1; done_auto = 1'b1;
    @(negedge clk);
    n_vec++;
    if (ctl !== 7'b0000001) begin
      n_err++; $display("FAIL timeout_sticky_idle: got ctl=%b want 0000001", ctl);
    end
    run = 1'b1;
    @(negedge clk);
    n_vec++;
    if (ctl !== 7'b1000001) begin
      n_err++; $display("FAIL timeout_sticky_fetch: got ctl=%b want 1000001", ctl);
    end
    run_instr(16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    done_auto = 1'b0; instr = 16'h0042;
    @(negedge clk);
    n_vec++;
    if (ctl !== 7'b0100001 || instr_q !== 16'h0042) begin
      n_err++; $display("FAIL rst_exec_pre: got ctl=%b instr_q=%h want 0100001 0042", ctl, instr_q);
    end
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if (ctl !== 7'b0) begin
      n_err++; $display("FAIL rst_async_ctl: got ctl=%b want 0000000", ctl);
    end
    n_vec++;
    if (instr_q !== 16'h0 || pc_in !== 16'h0) begin
      n_err++; $display("FAIL rst_async_data: got instr_q=%h pc_in=%h want 0000 0000", instr_q, pc_in);
    end
    run = 1'b0; done_auto = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (ctl !== 7'b0) begin
        n_err++; $display("FAIL rst_quiet_%0d: got ctl=%b want 0000000", i, ctl);
      end
    end
    $display("async reset during exec");
  endtask

  initial begin
    test_reset();
    test_a_instr();
    test_jump_cond();
    test_jump_self();
    test_pause();
    test_ack_at_limit();
    test_timeout();
    test_reset_in_exec();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
